// File: rtl/svpwm_pkg.sv
// rtl/svpwm_pkg.sv - shared types and constants for the SVPWM modulator
package svpwm_pkg;

  typedef logic signed [15:0] q15_t;

  localparam int SQRT3_HALF_Q15 = 28378;
  localparam int HALF_Q15       = 16384;

  localparam logic [1:0] PH_A = 2'd0;
  localparam logic [1:0] PH_B = 2'd1;
  localparam logic [1:0] PH_C = 2'd2;

  typedef enum logic [2:0] {
    SEC_NONE = 3'd0,
    SEC_1    = 3'd1,
    SEC_2    = 3'd2,
    SEC_3    = 3'd3,
    SEC_4    = 3'd4,
    SEC_5    = 3'd5,
    SEC_6    = 3'd6
  } sector_t;

  // Sector is named by which phase carries the largest and the smallest reference.
  function automatic sector_t sector_of(input logic [1:0] max_ph, input logic [1:0] min_ph);
    case ({max_ph, min_ph})
      {PH_A, PH_C}: return SEC_1;
      {PH_B, PH_C}: return SEC_2;
      {PH_B, PH_A}: return SEC_3;
      {PH_C, PH_A}: return SEC_4;
      {PH_C, PH_B}: return SEC_5;
      {PH_A, PH_B}: return SEC_6;
      default:      return SEC_1;
    endcase
  endfunction

endpackage

// File: rtl/svpwm_modulator_deadtime.sv
// rtl/svpwm_modulator_deadtime.sv - per-phase dead-band generator for one half-bridge
module svpwm_deadtime #(
  parameter int DEADTIME = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_raw,
  output logic o_h,
  output logic o_l
);

  localparam int CNTW = $clog2(DEADTIME + 3);

  logic [CNTW-1:0] r_run;
  logic            r_raw_d;
  logic [CNTW-1:0] w_run;

  // Length of the current raw run including this cycle, saturating just past DEADTIME.
  assign w_run = (i_raw != r_raw_d)               ? CNTW'(1) :
                 (r_run == CNTW'(DEADTIME + 1))   ? r_run    :
                                                    r_run + CNTW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run   <= '0;
      r_raw_d <= 1'b0;
      o_h     <= 1'b0;
      o_l     <= 1'b0;
    end else if (i_clr) begin
      r_run   <= '0;
      r_raw_d <= 1'b0;
      o_h     <= 1'b0;
      o_l     <= 1'b0;
    end else begin
      r_raw_d <= i_raw;
      r_run   <= w_run;
      o_h     <= i_raw  && (w_run > CNTW'(DEADTIME));
      o_l     <= !i_raw && (w_run > CNTW'(DEADTIME));
    end
  end

endmodule

// File: rtl/svpwm_modulator.sv
// rtl/svpwm_modulator.sv - SVPWM duty pipeline, shadowed compares, carrier and gate drive
module svpwm_modulator
  import svpwm_pkg::*;
#(
  parameter int DW       = 16,
  parameter int CW       = 12,
  parameter int PERIOD   = 2500,
  parameter int DEADTIME = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] alpha,
  input  logic signed [DW-1:0] beta,
  output logic                 pwm_ah,
  output logic                 pwm_al,
  output logic                 pwm_bh,
  output logic                 pwm_bl,
  output logic                 pwm_ch,
  output logic                 pwm_cl,
  output logic [CW-1:0]        cmp_a,
  output logic [CW-1:0]        cmp_b,
  output logic [CW-1:0]        cmp_c,
  output logic [2:0]           sector,
  output logic                 sat,
  output logic                 period_start
);

  // Returns {clamped, duty}; the offset uses a floor shift so negative refs round down.
  function automatic logic [CW:0] duty_of(input logic signed [18:0] v);
    logic signed [31:0] d;
    d = 32'(PERIOD / 2) + ((32'(v) * 32'(PERIOD)) >>> 16);
    if (d < 0)           return {1'b1, CW'(0)};
    else if (d > PERIOD) return {1'b1, CW'(PERIOD)};
    else                 return {1'b0, CW'(d)};
  endfunction

  logic                 r_v1, r_v2, r_v3;
  logic signed [DW-1:0] r_s1_alpha, r_s1_beta;
  logic signed [17:0]   r_s2_va, r_s2_vb, r_s2_vc;
  logic signed [18:0]   r_s3_va, r_s3_vb, r_s3_vc;
  sector_t              r_s3_sector;

  logic signed [31:0]   w_a_half, w_b_sq;
  logic signed [17:0]   w_max, w_min;
  logic [1:0]           w_max_ph, w_min_ph;
  logic signed [18:0]   w_vcm;
  logic [CW:0]          w_da, w_db, w_dc;

  logic [CW-1:0]        r_pend_a, r_pend_b, r_pend_c;
  sector_t              r_pend_sector;
  logic                 r_pend_sat, r_pend_valid;
  logic [CW-1:0]        r_cmp_a, r_cmp_b, r_cmp_c;
  sector_t              r_sector;
  logic                 r_sat;
  logic [CW-1:0]        r_cnt;
  logic                 r_dir_down;
  logic                 w_load;

  assign w_a_half = 32'(r_s1_alpha) * 32'(HALF_Q15);
  assign w_b_sq   = 32'(r_s1_beta)  * 32'(SQRT3_HALF_Q15);

  // Ties: max prefers a>b>c, min prefers c>b>a, so all-equal lands in sector 1.
  always_comb begin
    w_max_ph = PH_C;
    w_max    = r_s2_vc;
    if (r_s2_va >= r_s2_vb && r_s2_va >= r_s2_vc) begin
      w_max_ph = PH_A;
      w_max    = r_s2_va;
    end else if (r_s2_vb >= r_s2_vc) begin
      w_max_ph = PH_B;
      w_max    = r_s2_vb;
    end
    w_min_ph = PH_A;
    w_min    = r_s2_va;
    if (r_s2_vc <= r_s2_va && r_s2_vc <= r_s2_vb) begin
      w_min_ph = PH_C;
      w_min    = r_s2_vc;
    end else if (r_s2_vb <= r_s2_va) begin
      w_min_ph = PH_B;
      w_min    = r_s2_vb;
    end
  end

  assign w_vcm = (19'(w_max) + 19'(w_min)) >>> 1;
  assign w_da  = duty_of(r_s3_va);
  assign w_db  = duty_of(r_s3_vb);
  assign w_dc  = duty_of(r_s3_vc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_v3        <= 1'b0;
      r_s1_alpha  <= '0;
      r_s1_beta   <= '0;
      r_s2_va     <= '0;
      r_s2_vb     <= '0;
      r_s2_vc     <= '0;
      r_s3_va     <= '0;
      r_s3_vb     <= '0;
      r_s3_vc     <= '0;
      r_s3_sector <= SEC_NONE;
    end else begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (in_valid) begin
        r_s1_alpha <= alpha;
        r_s1_beta  <= beta;
      end
      if (r_v1) begin
        r_s2_va <= 18'(r_s1_alpha);
        r_s2_vb <= 18'((w_b_sq - w_a_half) >>> 15);
        r_s2_vc <= 18'((-w_a_half - w_b_sq) >>> 15);
      end
      if (r_v2) begin
        r_s3_va     <= 19'(r_s2_va) - w_vcm;
        r_s3_vb     <= 19'(r_s2_vb) - w_vcm;
        r_s3_vc     <= 19'(r_s2_vc) - w_vcm;
        r_s3_sector <= sector_of(w_max_ph, w_min_ph);
      end
    end
  end

  assign period_start = enable && (r_cnt == '0);
  assign w_load       = period_start && r_pend_valid;

  // A load and a new S4 result in the same cycle: load takes the old pending, new one stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_a      <= CW'(PERIOD / 2);
      r_pend_b      <= CW'(PERIOD / 2);
      r_pend_c      <= CW'(PERIOD / 2);
      r_pend_sector <= SEC_NONE;
      r_pend_sat    <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_cmp_a       <= CW'(PERIOD / 2);
      r_cmp_b       <= CW'(PERIOD / 2);
      r_cmp_c       <= CW'(PERIOD / 2);
      r_sector      <= SEC_NONE;
      r_sat         <= 1'b0;
    end else begin
      if (w_load) begin
        r_cmp_a      <= r_pend_a;
        r_cmp_b      <= r_pend_b;
        r_cmp_c      <= r_pend_c;
        r_sector     <= r_pend_sector;
        r_sat        <= r_pend_sat;
        r_pend_valid <= 1'b0;
      end
      if (r_v3) begin
        r_pend_a      <= w_da[CW-1:0];
        r_pend_b      <= w_db[CW-1:0];
        r_pend_c      <= w_dc[CW-1:0];
        r_pend_sector <= r_s3_sector;
        r_pend_sat    <= w_da[CW] | w_db[CW] | w_dc[CW];
        r_pend_valid  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_dir_down <= 1'b0;
    end else if (!enable) begin
      r_cnt      <= '0;
      r_dir_down <= 1'b0;
    end else if (!r_dir_down) begin
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == CW'(PERIOD - 1)) r_dir_down <= 1'b1;
    end else begin
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_dir_down <= 1'b0;
    end
  end

  svpwm_deadtime #(.DEADTIME(DEADTIME)) u_dt_a (
    .clk(clk), .rst(rst), .i_clr(!enable), .i_raw(r_cnt < r_cmp_a), .o_h(pwm_ah), .o_l(pwm_al)
  );
  svpwm_deadtime #(.DEADTIME(DEADTIME)) u_dt_b (
    .clk(clk), .rst(rst), .i_clr(!enable), .i_raw(r_cnt < r_cmp_b), .o_h(pwm_bh), .o_l(pwm_bl)
  );
  svpwm_deadtime #(.DEADTIME(DEADTIME)) u_dt_c (
    .clk(clk), .rst(rst), .i_clr(!enable), .i_raw(r_cnt < r_cmp_c), .o_h(pwm_ch), .o_l(pwm_cl)
  );

  assign cmp_a  = r_cmp_a;
  assign cmp_b  = r_cmp_b;
  assign cmp_c  = r_cmp_c;
  assign sector = r_sector;
  assign sat    = r_sat;

endmodule

// File: tb/tb_svpwm_modulator.sv
// tb/tb_svpwm_modulator.sv - directed scoreboard bench for svpwm_modulator
module tb_svpwm_modulator;

  localparam int PERIOD   = 2500;
  localparam int DEADTIME = 50;
  localparam int CW       = 12;

  logic               clk = 1'b0;
  logic               rst, enable, in_valid;
  logic signed [15:0] alpha, beta;
  logic               pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch, pwm_cl;
  logic [CW-1:0]      cmp_a, cmp_b, cmp_c;
  logic [2:0]         sector;
  logic               sat, period_start;

  int errors = 0;
  int checks = 0;

  typedef struct {int a; int b; int c; int sec; int sat;} exp_t;
  exp_t sb[$];
  exp_t last;

  always #5 clk = ~clk;

  svpwm_modulator #(.DW(16), .CW(CW), .PERIOD(PERIOD), .DEADTIME(DEADTIME)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .alpha(alpha), .beta(beta),
    .pwm_ah(pwm_ah), .pwm_al(pwm_al), .pwm_bh(pwm_bh), .pwm_bl(pwm_bl),
    .pwm_ch(pwm_ch), .pwm_cl(pwm_cl), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_c(cmp_c),
    .sector(sector), .sat(sat), .period_start(period_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int duty(input int v, output int clamped);
    int d;
    d = PERIOD / 2 + ((v * PERIOD) >>> 16);
    clamped = (d < 0 || d > PERIOD) ? 1 : 0;
    if (d < 0) d = 0;
    if (d > PERIOD) d = PERIOD;
    return d;
  endfunction

  // Reference model working straight from the alpha/beta equations.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int v[3];
    int mx, mn, vcm, s0, s1, s2;
    int sec_tab[3][3];
    sec_tab = '{'{1, 6, 1}, '{3, 1, 2}, '{4, 5, 1}};
    v[0] = a;
    v[1] = (-a * 16384 + b * 28378) >>> 15;
    v[2] = (-a * 16384 - b * 28378) >>> 15;
    mx = 2;
    for (int i = 1; i >= 0; i--) if (v[i] >= v[mx]) mx = i;
    mn = 0;
    for (int i = 1; i <= 2; i++) if (v[i] <= v[mn]) mn = i;
    vcm = (v[mx] + v[mn]) >>> 1;
    e.a = duty(v[0] - vcm, s0);
    e.b = duty(v[1] - vcm, s1);
    e.c = duty(v[2] - vcm, s2);
    e.sat = s0 | s1 | s2;
    e.sec = sec_tab[mx][mn];
    return e;
  endfunction

  task automatic push(input int a, input int b, input int c, input int sec, input int s);
    exp_t e;
    e.a = a; e.b = b; e.c = c; e.sec = sec; e.sat = s;
    sb.push_back(e);
  endtask

  task automatic send(input int a, input int b);
    @(posedge clk); #1;
    alpha = 16'(a); beta = 16'(b); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_load(input string tag, input int settle);
    bit seen;
    exp_t e;
    seen = 1'b0;
    repeat (settle) @(posedge clk);
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (period_start) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_boundary"}, 32'(seen), 32'd1);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({tag, "_cmp_a"}, 32'(cmp_a), e.a);
    chk({tag, "_cmp_b"}, 32'(cmp_b), e.b);
    chk({tag, "_cmp_c"}, 32'(cmp_c), e.c);
    chk({tag, "_sector"}, 32'(sector), e.sec);
    chk({tag, "_sat"}, 32'(sat), e.sat);
    last = e;
  endtask

  task automatic measure(output int h, output int l, output int lo, output int ov, output int ps);
    h = 0; l = 0; lo = 0; ov = 0; ps = 0;
    repeat (100) @(posedge clk);
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      h  += int'(pwm_ah);
      l  += int'(pwm_al);
      lo += int'(!pwm_ah && !pwm_al);
      ov += int'((pwm_ah && pwm_al) || (pwm_bh && pwm_bl) || (pwm_ch && pwm_cl));
      ps += int'(period_start);
    end
  endtask

  initial begin
    int h, l, lo, ov, ps, ra, rb;
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; alpha = '0; beta = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmp_a", 32'(cmp_a), 32'd1250);
    chk("rst_cmp_c", 32'(cmp_c), 32'd1250);
    chk("rst_sector", 32'(sector), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_gates", 32'({pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch, pwm_cl}), 32'd0);
    chk("rst_period_start", 32'(period_start), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 enable = 1'b1;
    @(negedge clk);
    chk("first_period_start", 32'(period_start), 32'd1);

    send(0, 0);
    push(1250, 1250, 1250, 1, 0);
    wait_load("zero", 6);
    // Counter visits 0 and PERIOD once per period, so cnt<1250 holds for 2499 cycles.
    measure(h, l, lo, ov, ps);
    chk("half_ah_high", h, 2449);
    chk("half_al_high", l, 2451);
    chk("half_deadband", lo, 2 * DEADTIME);
    chk("half_overlap", ov, 0);
    chk("half_period_pulses", ps, 1);

    send(16384, 0);
    push(1718, 781, 781, 1, 0);
    wait_load("alpha_half", 6);

    send(32767, 32767);
    push(2500, 1936, 0, 1, 1);
    wait_load("saturate", 6);

    repeat (50) @(posedge clk);
    send(16384, 0);
    send(-27245, -27245);
    push(20, 679, 2479, 4, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("hold_cmp_a", 32'(cmp_a), last.a);
    chk("hold_sat", 32'(sat), last.sat);
    wait_load("last_wins", 0);
    measure(h, l, lo, ov, ps);
    chk("narrow_ah_high", h, 0);
    chk("narrow_al_high", l, 4911);
    chk("narrow_overlap", ov, 0);

    for (int k = 0; k < 3; k++) begin
      ra = int'($urandom_range(65535)) - 32768;
      rb = int'($urandom_range(65535)) - 32768;
      sb.push_back(model(ra, rb));
      send(ra, rb);
      wait_load("random", 6);
    end

    repeat (300) @(posedge clk);
    send(16384, 0);
    push(1718, 781, 781, 1, 0);
    repeat (10) @(posedge clk);
    #1 enable = 1'b0;
    @(posedge clk); #1;
    chk("disable_gates", 32'({pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch, pwm_cl}), 32'd0);
    chk("disable_period_start", 32'(period_start), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("disable_hold_cmp_b", 32'(cmp_b), last.b);
    enable = 1'b1;
    wait_load("reenable", 0);

    repeat (400) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_gates", 32'({pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch, pwm_cl}), 32'd0);
    chk("async_rst_cmp_a", 32'(cmp_a), 32'd1250);
    chk("async_rst_cmp_b", 32'(cmp_b), 32'd1250);
    chk("async_rst_sector", 32'(sector), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
